rd_tid_alloc: RTL and testbench
===============================

Name: rd_tid_alloc

Overview:
- Front stage of the DRAM-cache read path. Accepts AXI read-address requests and tags each with a sequential transaction ID (tID), starting at 1, matching the ROB's expected-tID sequence.
- Records the AXI ARID per tID and forwards the request plus tID to tag compare.
- Returns the original ARID for each transaction the ROB retires, in order.
- Limits outstanding transactions to MAX_OUTSTANDING so the ROB hit/miss FIFOs cannot overflow.

Parameters:
- ID_WIDTH, `AXI_ID_WIDTH, AXI ARID/RID width.
- ADDR_WIDTH, `AXI_ADDR_WIDTH, AXI address width.
- TID_WIDTH, `TID_WIDTH, internal transaction-ID width.
- MAX_OUTSTANDING, `FIFO_SIZE, maximum allocated-but-unretired tIDs. Must be ≤ 2^TID_WIDTH − 1.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- arvalid_i, input, 1, AXI AR valid.
- arready_o, output, 1, AXI AR ready.
- arid_i, input, ID_WIDTH, AXI ARID.
- araddr_i, input, ADDR_WIDTH, AXI read address.
- req_valid_o, output, 1, request valid to tag compare.
- req_ready_i, input, 1, tag compare ready.
- req_tid_o, output, TID_WIDTH, tID of the forwarded request.
- req_addr_o, output, ADDR_WIDTH, address of the forwarded request.
- retire_i, input, 1, one pulse per ROB output handshake (ROB valid_o & ready_i).
- rid_o, output, ID_WIDTH, ARID of the oldest unretired tID. Combinational read of the table.
- outstanding_o, output, TID_WIDTH+1, count of allocated, unretired tIDs.
- err_o, output, 1, sticky: retire seen with zero outstanding.

Behaviour:
- Single clock domain; reset is synchronous, active-low on rst_n.
- Reset values:
  - alloc_tid = 1, ret_tid = 1, outstanding = 0.
  - req_valid_o = 0, req_tid_o = 0, req_addr_o = 0.
  - err_o = 0, arready_o = 0 while rst_n is low.
  - ID table contents are not reset.
- ID table: 2^TID_WIDTH entries × ID_WIDTH, indexed by tID. One write port (allocate) and one async read port (retire).
- Output register: a single-entry pipeline stage holding {tid, addr}.
- States:
  - S_IDLE: register empty.
  - S_VAL: register holds a request, req_valid_o = 1.
- arready_o = (outstanding < MAX_OUTSTANDING) & (state == S_IDLE | req_ready_i). This allows back-to-back acceptance: one request per cycle when downstream is always ready.
- Accept (arvalid_i & arready_o), applied on the next edge:
  - register ← {alloc_tid, araddr_i}
  - table[alloc_tid] ← arid_i
  - alloc_tid ← alloc_tid + 1 (modulo 2^TID_WIDTH, so it wraps through 0, same as the ROB counter)
  - outstanding + 1
  - state → S_VAL
- In S_VAL:
  - req_ready_i without accept → S_IDLE.
  - req_ready_i with accept → stays in S_VAL with the new contents.
  - No req_ready_i → hold; req_tid_o and req_addr_o are stable while valid.
- Latency: AR accept to req_valid_o is 1 cycle.
- Retire (retire_i & outstanding != 0):
  - rid_o is valid in the same cycle, equal to table[ret_tid].
  - Next edge: ret_tid + 1 (modulo), outstanding − 1.
- Retire with outstanding == 0: ignored, err_o ← 1 (sticky until reset).
- Accept and retire in the same cycle: outstanding unchanged, both pointers advance. If the table indices collide, the table write does not affect this cycle's rid_o.
- Full: outstanding == MAX_OUTSTANDING forces arready_o = 0. A retire in that cycle does not re-open arready_o until the next cycle.
- Reset mid-operation: all pointers, the count, and the output register are cleared; in-flight requests are dropped. Upstream and the ROB are reset together.

Decomposition:
- Shared package/TYPEDEF.svh holds:
  - `TID_WIDTH, `FIFO_SIZE, `AXI_ID_WIDTH, `AXI_ADDR_WIDTH
  - TID_RESET_VAL = 1, shared with the ROB's tID reset.
  - localparams S_IDLE/S_VAL.
- One sub-module, tid_id_table: a simple dual-port register file, synchronous write and async read, parameterised by depth and width.

Test Plan:
1. Reset, then 3 ARs (ARID 5, 9, 2) with req_ready_i = 1 → req_tid_o 1, 2, 3 on consecutive cycles; outstanding_o = 3. Then 3 retires → rid_o 5, 9, 2 in order; outstanding_o = 0.
2. MAX_OUTSTANDING = 4, arvalid held, no retires → exactly 4 accepts, then arready_o = 0. One retire → arready_o = 1 the following cycle; the 5th accept gets tID 5.
3. req_ready_i = 0 for 5 cycles with a request loaded → req_valid_o = 1 with stable tid/addr throughout, arready_o = 0, no second allocation.
4. TID_WIDTH = 3, 20 sequential alloc/retire pairs → tIDs run 1..7, 0, 1, …; rid_o always matches the ARID of the same tID.
5. Accept and retire in the same cycle at outstanding = 2 → outstanding stays 2, and rid_o equals the older ARID.
6. retire_i pulse right after reset → err_o = 1 and stays 1; outstanding_o stays 0. Then assert rst_n = 0 mid-traffic → req_valid_o = 0, outstanding_o = 0, next tID = 1, err_o = 0.

Source files
------------

// File: rtl/rd_tid_alloc_pkg.sv
// Shared definitions for the read-path tID allocator: default widths, the tID
// reset value common with the ROB, and the output-stage state encoding.
package rd_tid_alloc_pkg;

  localparam int TID_WIDTH      = 4;
  localparam int FIFO_SIZE      = 8;
  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_ADDR_WIDTH = 32;

  // Must match the ROB's expected-tID reset so both sides start in step.
  localparam int TID_RESET_VAL  = 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_VAL  = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/rd_tid_alloc_tid_table.sv
// ARID table indexed by tID: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; an entry is only read after it was written.
module rd_tid_alloc_tid_table #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A same-cycle write to this index lands at the edge, so the read sees old data.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/rd_tid_alloc.sv
// Read-path front stage: tags each accepted AR with a sequential tID, records its
// ARID for in-order return at ROB retire, and caps allocated-but-unretired tIDs.
module rd_tid_alloc
  import rd_tid_alloc_pkg::*;
#(
  parameter int ID_WIDTH        = AXI_ID_WIDTH,
  parameter int ADDR_WIDTH      = AXI_ADDR_WIDTH,
  parameter int TID_WIDTH       = rd_tid_alloc_pkg::TID_WIDTH,
  parameter int MAX_OUTSTANDING = FIFO_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [ID_WIDTH-1:0]   arid_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [TID_WIDTH-1:0]  req_tid_o,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  input  logic                  retire_i,
  output logic [ID_WIDTH-1:0]   rid_o,
  output logic [TID_WIDTH:0]    outstanding_o,
  output logic                  err_o
);

  localparam logic [TID_WIDTH:0]   MAX_OUT = (TID_WIDTH+1)'(MAX_OUTSTANDING);
  localparam logic [TID_WIDTH-1:0] TID_RST = TID_WIDTH'(TID_RESET_VAL);
  localparam int                   DEPTH   = 1 << TID_WIDTH;

  alloc_state_e            state_q;
  logic [TID_WIDTH-1:0]    alloc_tid_q, alloc_tid_d;
  logic [TID_WIDTH-1:0]    ret_tid_q, ret_tid_d;
  logic [TID_WIDTH:0]      outstanding_q, outstanding_d;
  logic [TID_WIDTH-1:0]    req_tid_q;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic                    err_q, err_d;
  logic                    accept;
  logic                    retire_ok;

  // Ready is held low during reset even though the state is only cleared at the edge.
  assign arready_o = rst_n && (outstanding_q < MAX_OUT) &&
                     ((state_q == S_IDLE) || req_ready_i);
  assign accept    = arvalid_i && arready_o;
  assign retire_ok = retire_i && (outstanding_q != '0);

  always_comb begin
    alloc_tid_d   = alloc_tid_q;
    ret_tid_d     = ret_tid_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;
    if (accept) begin
      alloc_tid_d = alloc_tid_q + 1'b1;
    end
    if (retire_ok) begin
      ret_tid_d = ret_tid_q + 1'b1;
    end
    case ({accept, retire_ok})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
    if (retire_i && (outstanding_q == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      req_tid_q     <= '0;
      req_addr_q    <= '0;
      alloc_tid_q   <= TID_RST;
      ret_tid_q     <= TID_RST;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      alloc_tid_q   <= alloc_tid_d;
      ret_tid_q     <= ret_tid_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q    <= S_VAL;
            req_tid_q  <= alloc_tid_q;
            req_addr_q <= araddr_i;
          end
        end
        S_VAL: begin
          // Accept in S_VAL implies req_ready_i, so the slot is refilled in place.
          if (accept) begin
            req_tid_q  <= alloc_tid_q;
            req_addr_q <= araddr_i;
          end else if (req_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  rd_tid_alloc_tid_table #(
    .DEPTH (DEPTH),
    .WIDTH (ID_WIDTH),
    .AW    (TID_WIDTH)
  ) u_tid_table (
    .clk       (clk),
    .wr_en_i   (accept),
    .wr_addr_i (alloc_tid_q),
    .wr_data_i (arid_i),
    .rd_addr_i (ret_tid_q),
    .rd_data_o (rid_o)
  );

  assign req_valid_o   = (state_q == S_VAL);
  assign req_tid_o     = req_tid_q;
  assign req_addr_o    = req_addr_q;
  assign outstanding_o = outstanding_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_rd_tid_alloc.sv
// Directed bench for rd_tid_alloc: stimulus pushes expected requests/RIDs into
// queues and a negedge monitor pops and compares them as the DUT presents them.
module tb_rd_tid_alloc;

  localparam int IDW  = 4;
  localparam int AW   = 16;
  localparam int TW   = 3;
  localparam int MAXO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            arvalid_i = 1'b0;
  logic            req_ready_i = 1'b0;
  logic            retire_i = 1'b0;
  logic            arready_o, req_valid_o, err_o;
  logic [IDW-1:0]  arid_i = '0;
  logic [IDW-1:0]  rid_o;
  logic [AW-1:0]   araddr_i = '0;
  logic [AW-1:0]   req_addr_o;
  logic [TW-1:0]   req_tid_o;
  logic [TW:0]     outstanding_o;

  int total = 0;
  int bad   = 0;

  logic [TW-1:0]  exp_tid_q[$];
  logic [AW-1:0]  exp_addr_q[$];
  logic [IDW-1:0] exp_rid_q[$];

  logic [IDW-1:0] m_tbl [8];
  logic [TW-1:0]  m_alloc = 3'd1;
  logic [TW-1:0]  m_ret = 3'd1;
  int             m_out = 0;

  logic [TW-1:0]  mon_tid;
  logic [AW-1:0]  mon_addr;
  logic [IDW-1:0] mon_rid;

  rd_tid_alloc #(
    .ID_WIDTH        (IDW),
    .ADDR_WIDTH      (AW),
    .TID_WIDTH       (TW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arvalid_i     (arvalid_i),
    .arready_o     (arready_o),
    .arid_i        (arid_i),
    .araddr_i      (araddr_i),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_tid_o     (req_tid_o),
    .req_addr_o    (req_addr_o),
    .retire_i      (retire_i),
    .rid_o         (rid_o),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_accept(input logic [IDW-1:0] id, input logic [AW-1:0] addr);
    exp_tid_q.push_back(m_alloc);
    exp_addr_q.push_back(addr);
    m_tbl[m_alloc] = id;
    m_alloc = m_alloc + 1'b1;
    m_out++;
  endtask

  task automatic note_retire;
    if (m_out > 0) begin
      exp_rid_q.push_back(m_tbl[m_ret]);
      m_ret = m_ret + 1'b1;
      m_out--;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    arvalid_i = 1'b0;
    retire_i = 1'b0;
    exp_tid_q.delete();
    exp_addr_q.delete();
    exp_rid_q.delete();
    m_alloc = 3'd1;
    m_ret = 3'd1;
    m_out = 0;
    @(negedge clk);
    chk("rst_arready", arready_o, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic ar_issue(input logic [IDW-1:0] id, input logic [AW-1:0] addr);
    bit ok;
    ok = 0;
    arvalid_i = 1'b1;
    arid_i = id;
    araddr_i = addr;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (arready_o) ok = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (ok) note_accept(id, addr);
    else begin
      total++;
      bad++;
      $display("FAIL ar_timeout: got no arready expected arready for id %0h", id);
    end
    @(posedge clk);
    #1;
    arvalid_i = 1'b0;
  endtask

  task automatic retire_pulse;
    retire_i = 1'b1;
    note_retire();
    @(posedge clk);
    #1;
    retire_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid_o && req_ready_i) begin
        if (exp_tid_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL req_unexpected: got tid %0d expected none", req_tid_o);
        end else begin
          mon_tid  = exp_tid_q.pop_front();
          mon_addr = exp_addr_q.pop_front();
          chk("req_tid", req_tid_o, mon_tid);
          chk("req_addr", req_addr_o, mon_addr);
        end
      end
      if (retire_i && exp_rid_q.size() > 0) begin
        mon_rid = exp_rid_q.pop_front();
        chk("rid", rid_o, mon_rid);
      end
    end
  end

  initial begin
    int n_acc;

    // 1: three back-to-back requests, then three in-order retires
    do_reset();
    chk("rst_req_valid", req_valid_o, 0);
    chk("rst_req_tid", req_tid_o, 0);
    chk("rst_req_addr", req_addr_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    req_ready_i = 1'b1;
    ar_issue(4'd5, 16'h1000);
    chk("t1_tid_first", req_tid_o, 1);
    ar_issue(4'd9, 16'h1004);
    ar_issue(4'd2, 16'h1008);
    chk("t1_outstanding3", outstanding_o, 3);
    chk("t1_rid_head", rid_o, 5);
    retire_pulse();
    retire_pulse();
    retire_pulse();
    chk("t1_outstanding0", outstanding_o, 0);

    // 2: fill to MAX_OUTSTANDING, retire re-opens ready one cycle later
    do_reset();
    req_ready_i = 1'b1;
    n_acc = 0;
    arvalid_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      arid_i = IDW'(c + 1);
      araddr_i = AW'(16'h2000 + c);
      @(negedge clk);
      if (arready_o) begin
        note_accept(arid_i, araddr_i);
        n_acc++;
      end
      @(posedge clk);
      #1;
    end
    chk("t2_accepts", n_acc, 4);
    chk("t2_full_arready", arready_o, 0);
    chk("t2_full_count", outstanding_o, 4);
    retire_i = 1'b1;
    note_retire();
    @(negedge clk);
    chk("t2_retire_same_cycle_arready", arready_o, 0);
    @(posedge clk);
    #1 retire_i = 1'b0;
    @(negedge clk);
    chk("t2_reopen_arready", arready_o, 1);
    if (arready_o) note_accept(arid_i, araddr_i);
    @(posedge clk);
    #1 arvalid_i = 1'b0;
    chk("t2_fifth_tid", req_tid_o, 5);
    chk("t2_count_after", outstanding_o, 4);
    repeat (4) retire_pulse();
    chk("t2_drained", outstanding_o, 0);

    // 3: downstream stall holds the request stable and blocks further accepts
    do_reset();
    req_ready_i = 1'b0;
    ar_issue(4'd7, 16'h3A5C);
    arvalid_i = 1'b1;
    arid_i = 4'd8;
    araddr_i = 16'h1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_valid", req_valid_o, 1);
      chk("t3_tid", req_tid_o, 1);
      chk("t3_addr", req_addr_o, 16'h3A5C);
      chk("t3_arready", arready_o, 0);
      @(posedge clk);
      #1;
    end
    arvalid_i = 1'b0;
    chk("t3_outstanding", outstanding_o, 1);
    req_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_drained_valid", req_valid_o, 0);
    retire_pulse();

    // 4: 20 alloc/retire pairs across the 3-bit tID wrap
    do_reset();
    req_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ar_issue(IDW'(i * 5 + 3), AW'(16'h4000 + i));
      chk("t4_wrap_tid", req_tid_o, (i + 1) % 8);
      retire_pulse();
    end
    chk("t4_outstanding", outstanding_o, 0);

    // 5: accept and retire in the same cycle at outstanding = 2
    do_reset();
    req_ready_i = 1'b1;
    ar_issue(4'hA, 16'h5000);
    ar_issue(4'hB, 16'h5004);
    chk("t5_pre_count", outstanding_o, 2);
    arvalid_i = 1'b1;
    arid_i = 4'hC;
    araddr_i = 16'h5008;
    retire_i = 1'b1;
    note_retire();
    @(negedge clk);
    chk("t5_arready", arready_o, 1);
    chk("t5_rid_older", rid_o, 4'hA);
    if (arready_o) note_accept(arid_i, araddr_i);
    @(posedge clk);
    #1;
    arvalid_i = 1'b0;
    retire_i = 1'b0;
    chk("t5_count_same", outstanding_o, 2);
    chk("t5_rid_next", rid_o, 4'hB);
    retire_pulse();
    retire_pulse();

    // 6: spurious retire sets sticky error; reset mid-traffic clears everything
    do_reset();
    retire_pulse();
    chk("t6_err_set", err_o, 1);
    chk("t6_count_zero", outstanding_o, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_err_sticky", err_o, 1);
    req_ready_i = 1'b0;
    ar_issue(4'd6, 16'h6000);
    chk("t6_inflight_valid", req_valid_o, 1);
    do_reset();
    chk("t6_rst_valid", req_valid_o, 0);
    chk("t6_rst_count", outstanding_o, 0);
    chk("t6_rst_err", err_o, 0);
    req_ready_i = 1'b1;
    ar_issue(4'hD, 16'h6010);
    chk("t6_restart_tid", req_tid_o, 1);
    retire_pulse();

    repeat (3) @(posedge clk);
    #1;
    chk("end_req_queue_empty", exp_tid_q.size(), 0);
    chk("end_rid_queue_empty", exp_rid_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
